ro_freq_meter: RTL and testbench
================================

RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter WIN_W, default 16: width of window length, in clk cycles.
REQ-002 SHALL have parameter CNT_W, default 16: width of edge-count result.
REQ-003 SHALL have parameter SETTLE_CYC, default 4: oscillator settle/synchronizer flush cycles, >=3.
REQ-004 SHALL have port clk  input  1: system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1: measurement request, sampled only in IDLE.
REQ-007 SHALL have port win_len  input  WIN_W: measurement window length, captured with start.
REQ-008 SHALL have port ro_in  input  1: ring oscillator output, asynchronous to clk.
REQ-009 SHALL have port ro_en  output  1: ring oscillator enable.
REQ-010 SHALL have port busy  output  1: high whenever state != IDLE.
REQ-011 SHALL have port result  output  CNT_W: rising-edge count of the last window.
REQ-012 SHALL have port overflow  output  1: result saturated.
REQ-013 SHALL have port result_valid  output  1: result/overflow valid.
REQ-014 SHALL have port result_ready  input  1: consumer accepts result.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, MEASURE, DONE; all outputs registered.
REQ-016 SHALL, in IDLE with start=1 at edge k, capture win_len into win_reg, clear edge count and overflow, and enter SETTLE at edge k (or DONE if win_len=0).
REQ-017 SHALL drive ro_en=1 in SETTLE and MEASURE only; 0 in IDLE and DONE.
REQ-018 SHALL synchronize ro_in through a 2-flop chain plus one history flop; rising edge = sync2 & ~hist.
REQ-019 SHALL remain in SETTLE exactly SETTLE_CYC cycles, ignoring detected edges, then enter MEASURE.
REQ-020 SHALL remain in MEASURE exactly win_reg cycles, counting one per detected edge, including an edge detected in the last MEASURE cycle.
REQ-021 SHALL saturate count at 2^CNT_W-1 and set overflow=1 on any edge arriving at saturation.
REQ-022 SHALL assert result_valid from edge k+SETTLE_CYC+win_reg onward (DONE), with result/overflow stable while in DONE.
REQ-023 SHALL, for win_len=0, enter DONE at edge k with result=0, overflow=0, ro_en never asserted.
REQ-024 SHALL hold DONE until result_valid & result_ready sampled high, then enter IDLE next edge and drop result_valid; result keeps last value.
REQ-025 SHALL ignore start in SETTLE, MEASURE, DONE; changes to win_len after capture SHALL have no effect.
REQ-026 SHALL accept a new start no earlier than the first IDLE cycle after handshake.

Reset
REQ-027 SHALL, on rst_n=0, immediately force state=IDLE, ro_en=0, busy=0, result=0, overflow=0, result_valid=0, synchronizer/history flops=0, count=0, win_reg=0.
REQ-028 SHALL abort any in-progress measurement on reset with no result delivered; normal operation resumes at first clk edge after rst_n rises.

Verification (SETTLE_CYC=4, WIN_W=8, CNT_W=8 unless stated)
REQ-029 SHALL verify: ro_in period 4 clk, start with win_len=40 at edge k -> ro_en high edges k..k+43, result_valid at k+44, result=10, overflow=0.
REQ-030 SHALL verify: ro_in held 0, win_len=16 -> result=0, overflow=0, result_valid at k+20.
REQ-031 SHALL verify: CNT_W=4 build, ro_in period 2 clk, win_len=100 -> result=15, overflow=1.
REQ-032 SHALL verify: win_len=0 -> result_valid at k, result=0, ro_en stays 0.
REQ-033 SHALL verify: result_ready low 10 cycles in DONE with start pulses -> result/result_valid stable, starts ignored; ready high -> IDLE next edge, busy=0.
REQ-034 SHALL verify: rst_n low mid-MEASURE -> all outputs 0 asynchronously, no result_valid; fresh start afterwards yields correct count.

Source files
------------

// File: rtl/ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : ro_freq_meter
// Description : Ring-oscillator frequency meter. Enables the oscillator, lets
//               it settle while the synchronizer flushes, then counts rising
//               edges of ro_in over a programmable window of clk cycles. The
//               saturating count is offered with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_freq_meter #(
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ro_in,
    output logic             ro_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);

    // One timer serves both the settle phase and the measurement window, so
    // it is as wide as whichever of the two needs more bits.
    localparam int C_SET_W = $clog2(SETTLE_CYC + 1);
    localparam int C_TMR_W = (WIN_W > C_SET_W) ? WIN_W : C_SET_W;

    localparam logic [C_TMR_W-1:0] C_SETTLE_LAST = C_TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   C_CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_TMR_W-1:0] r_tmr;
    logic [C_TMR_W-1:0] w_tmr_nxt;
    logic [C_TMR_W-1:0] w_win_last;
    logic [WIN_W-1:0]   r_win;
    logic [WIN_W-1:0]   w_win_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               w_ovf_inc;
    logic [CNT_W-1:0]   w_result_nxt;
    logic               w_overflow_nxt;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_hist;
    logic               w_rise;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_rise     = r_sync2 & ~r_hist;
    assign w_win_last = C_TMR_W'(r_win) - C_TMR_W'(1);

    // Next-state, timer, counter and result computation.
    always_comb begin
        w_state_nxt    = r_state;
        w_tmr_nxt      = r_tmr;
        w_win_nxt      = r_win;
        w_cnt_nxt      = r_cnt;
        w_ovf_nxt      = r_ovf;
        w_result_nxt   = result;
        w_overflow_nxt = overflow;

        // Count value including this cycle's edge; an edge at saturation
        // only raises the overflow flag.
        w_cnt_inc = r_cnt;
        w_ovf_inc = r_ovf;
        if (w_rise) begin
            if (r_cnt == C_CNT_MAX) begin
                w_ovf_inc = 1'b1;
            end else begin
                w_cnt_inc = r_cnt + 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_win_nxt = win_len;
                    w_cnt_nxt = '0;
                    w_ovf_nxt = 1'b0;
                    w_tmr_nxt = '0;
                    if (win_len == '0) begin
                        // Empty window: report zero without touching the oscillator.
                        w_state_nxt    = S_DONE;
                        w_result_nxt   = '0;
                        w_overflow_nxt = 1'b0;
                    end else begin
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (r_tmr == C_SETTLE_LAST) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_MEASURE;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_MEASURE: begin
                w_cnt_nxt = w_cnt_inc;
                w_ovf_nxt = w_ovf_inc;
                if (r_tmr == w_win_last) begin
                    // The edge seen in the final window cycle is included.
                    w_state_nxt    = S_DONE;
                    w_result_nxt   = w_cnt_inc;
                    w_overflow_nxt = w_ovf_inc;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tmr        <= '0;
            r_win        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            result       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            ro_en        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tmr        <= w_tmr_nxt;
            r_win        <= w_win_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ovf        <= w_ovf_nxt;
            result       <= w_result_nxt;
            overflow     <= w_overflow_nxt;
            result_valid <= (w_state_nxt == S_DONE);
            busy         <= (w_state_nxt != S_IDLE);
            ro_en        <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_freq_meter
// Description : Scoreboard bench for ro_freq_meter. Stimulus pushes expected
//               results; a monitor pops them on each rising result_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_freq_meter;

    localparam int SETTLE = 4;

    typedef struct {
        int res;
        bit ovf;
        int vcyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] win_len = 8'd0;
    logic       ro_in = 1'b0;
    logic       ready = 1'b0;
    logic       ro_en, busy, ovf, rv;
    logic [7:0] res;

    logic       start4 = 1'b0;
    logic [7:0] win_len4 = 8'd0;
    logic       ro_en4, busy4, ovf4, rv4;
    logic [3:0] res4;

    int   cyc = 0;
    int   ro_period = 0;
    int   ro_ph = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q4[$];
    bit   rv_q = 1'b0;
    bit   rv4_q = 1'b0;

    ro_freq_meter #(.WIN_W(8), .CNT_W(8), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .result(res),
        .overflow(ovf), .result_valid(rv), .result_ready(ready)
    );

    ro_freq_meter #(.WIN_W(8), .CNT_W(4), .SETTLE_CYC(SETTLE)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .win_len(win_len4),
        .ro_in(ro_in), .ro_en(ro_en4), .busy(busy4), .result(res4),
        .overflow(ovf4), .result_valid(rv4), .result_ready(ready)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator model, changed away from the sampling edge.
    always @(negedge clk) begin
        ro_ph = ro_ph + 1;
        ro_in = (ro_period != 0) && ((ro_ph % ro_period) < (ro_period / 2));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each newly presented result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rv && !rv_q) begin
            if (q8.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("result", int'(res), e.res);
                chk("overflow", int'(ovf), int'(e.ovf));
                chk("valid_cycle", cyc, e.vcyc);
            end
        end
        if (rv4 && !rv4_q) begin
            if (q4.size() == 0) begin
                chk("unexpected_valid4", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("result4", int'(res4), e.res);
                chk("overflow4", int'(ovf4), int'(e.ovf));
                chk("valid_cycle4", cyc, e.vcyc);
            end
        end
        rv_q  = rv;
        rv4_q = rv4;
    end

    // Hold DONE with ready low and stray starts, then complete the handshake.
    task automatic handshake(input int hold, input int exp_res, input bit exp_ovf);
        for (int i = 0; i < hold; i++) begin
            start   = (i % 3 == 0);
            win_len = 8'd5;
            @(negedge clk);
            chk("hold_valid", int'(rv), 1);
            chk("hold_result", int'(res), exp_res);
            chk("hold_ovf", int'(ovf), int'(exp_ovf));
            chk("hold_ro_en", int'(ro_en), 0);
        end
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("post_hs_valid", int'(rv), 0);
        chk("post_hs_busy", int'(busy), 0);
        chk("post_hs_result", int'(res), exp_res);
    endtask

    task automatic measure8(input int period, input int win, input int exp_res,
                            input bit exp_ovf, input int hold);
        exp_t e;
        int   k;
        int   t;
        ro_period = period;
        repeat (3) @(negedge clk);
        start   = 1'b1;
        win_len = 8'(win);
        k       = cyc + 1;
        e.res   = exp_res;
        e.ovf   = exp_ovf;
        e.vcyc  = (win == 0) ? k : k + SETTLE + win;
        q8.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        win_len = 8'd3;
        if (win == 0) begin
            chk("ro_en_zero_win", int'(ro_en), 0);
        end else begin
            for (int n = 0; n < SETTLE + win; n++) begin
                chk("ro_en_active", int'(ro_en), 1);
                chk("busy_active", int'(busy), 1);
                @(negedge clk);
            end
            chk("ro_en_done", int'(ro_en), 0);
        end
        t = 0;
        while (!rv && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!rv) chk("valid_timeout", 0, 1);
        else handshake(hold, exp_res, exp_ovf);
    endtask

    initial begin
        exp_t e;
        int   k;
        int   t;

        // Reset state.
        #2;
        chk("rst_ro_en", int'(ro_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(res), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_valid", int'(rv), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        measure8(4, 40, 10, 1'b0, 2);    // period 4 over 40 cycles
        measure8(0, 16, 0, 1'b0, 1);     // oscillator held low
        measure8(0, 0, 0, 1'b0, 1);      // empty window
        measure8(4, 40, 10, 1'b0, 10);   // long stall with ignored starts
        measure8(2, 20, 10, 1'b0, 1);    // period 2 over 20 cycles

        // Saturation on the narrow-count instance.
        ro_period = 2;
        repeat (3) @(negedge clk);
        start4   = 1'b1;
        win_len4 = 8'd100;
        k        = cyc + 1;
        e.res    = 15;
        e.ovf    = 1'b1;
        e.vcyc   = k + SETTLE + 100;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        t = 0;
        while (!rv4 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!rv4) chk("valid4_timeout", 0, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("post_hs_valid4", int'(rv4), 0);
        chk("post_hs_busy4", int'(busy4), 0);

        // Reset in the middle of a measurement.
        ro_period = 4;
        @(negedge clk);
        start   = 1'b1;
        win_len = 8'd40;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ro_en", int'(ro_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_result", int'(res), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_valid", int'(rv), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_valid_after_rst", int'(rv), 0);
        measure8(4, 20, 5, 1'b0, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q8.size() + q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
